// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle between the datapath clients, the shared ALU and alu_share_arbiter.
// master = clients plus ALU side, slave = arbiter.
interface alu_share_arbiter_if #(
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [4*NREQ-1:0]    req_op;
   logic [64*NREQ-1:0]   req_a;
   logic [64*NREQ-1:0]   req_b;
   logic [3:0]           alu_opr;
   logic [63:0]          alu_a;
   logic [63:0]          alu_b;
   logic [63:0]          alu_result;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [IDW-1:0]       resp_id;
   logic [63:0]          resp_data;
   logic                 resp_err;
   logic                 busy;

   modport master (
      output req_valid, req_op, req_a, req_b, alu_result, resp_ready,
      input  req_ready, alu_opr, alu_a, alu_b, resp_valid, resp_id, resp_data, resp_err, busy
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, alu_result, resp_ready,
      output req_ready, alu_opr, alu_a, alu_b, resp_valid, resp_id, resp_data, resp_err, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one 64-bit ALU among NREQ requesters.
// Optional illegal-opcode trap is enabled by defining ALU_ARB_OPCHECK_EN.
//
// state  | meaning
// IDLE   | no op in flight; grant any valid requester
// EXEC   | issue registers drive the ALU; result captured at end of cycle
// RESP   | response held until resp_ready; back-to-back accept allowed
module alu_share_arbiter #(
   parameter int NREQ = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   alu_share_arbiter_if.slave  bus
);
   localparam int IDW = $clog2(NREQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   state_t         state;
   logic [IDW-1:0] last_gnt;
   logic [IDW-1:0] gnt;
   logic [IDW-1:0] cur_id;
   logic           cur_err;
   logic           any_valid;
   logic           can_accept;
   logic           accept;
   logic           sel_illegal;
   logic [3:0]     sel_op;

   // Search starts one past the last winner and wraps modulo NREQ.
   always_comb begin
      int             idx;
      logic           found;
      logic [IDW-1:0] cand;
      gnt   = last_gnt;
      found = 1'b0;
      idx   = 0;
      cand  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = int'(last_gnt) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = IDW'(idx);
         if (!found && bus.req_valid[cand]) begin
            gnt   = cand;
            found = 1'b1;
         end
      end
   end

   assign any_valid     = |bus.req_valid;
   assign can_accept    = (state == S_IDLE) || ((state == S_RESP) && bus.resp_ready);
   assign accept        = can_accept && any_valid;
   assign bus.req_ready = accept ? (NREQ'(1) << gnt) : '0;
   assign sel_op        = bus.req_op[4*gnt +: 4];

`ifdef ALU_ARB_OPCHECK_EN
   assign sel_illegal = (sel_op > 4'd10);
`else
   assign sel_illegal = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         last_gnt       <= IDW'(NREQ-1);
         cur_id         <= '0;
         cur_err        <= 1'b0;
         bus.alu_opr    <= 4'd0;
         bus.alu_a      <= '0;
         bus.alu_b      <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_id    <= '0;
         bus.resp_data  <= '0;
         bus.resp_err   <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state    <= S_EXEC;
                  bus.busy <= 1'b1;
               end
            end
            S_EXEC: begin
               // A trapped opcode ran as add on the ALU, so its result is discarded.
               bus.resp_data  <= cur_err ? '0 : bus.alu_result;
               bus.resp_id    <= cur_id;
               bus.resp_err   <= cur_err;
               bus.resp_valid <= 1'b1;
               state          <= S_RESP;
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  if (any_valid) begin
                     state <= S_EXEC;
                  end else begin
                     state    <= S_IDLE;
                     bus.busy <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
            end
         endcase

         if (accept) begin
            last_gnt    <= gnt;
            cur_id      <= gnt;
            cur_err     <= sel_illegal;
            bus.alu_opr <= sel_illegal ? 4'd0 : sel_op;
            bus.alu_a   <= bus.req_a[64*gnt +: 64];
            bus.alu_b   <= bus.req_b[64*gnt +: 64];
         end
      end
   end
endmodule
